// File: rtl/des_round_pipe.sv
// des_round_pipe: two-stage pipelined DES Feistel round.
//
// Stage 1 captures E(R) ^ K together with L, R and the last-round flag.
// Stage 2 runs the eight S-boxes and P on the captured value, XORs the result
// into L and registers the new halves.
// Valid/ready on both sides with full backpressure. There is no skid buffer,
// so stage 1 can only accept while stage 2 is able to advance.
//
// Ports:
//   clk, n_rst            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   upstream handshake for l_in, r_in, subkey, last_round
//   l_in, r_in            L(i-1), R(i-1); DES bit 1 is bit [31]
//   subkey                K(i); DES bit 1 is bit [47]
//   last_round            1 = round 16, so the halves are not swapped
//   out_valid / out_ready downstream handshake for l_out, r_out
//   l_out, r_out          new left and right halves
module des_round_pipe (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] l_in,
    input  logic [31:0] r_in,
    input  logic [47:0] subkey,
    input  logic        last_round,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] l_out,
    output logic [31:0] r_out
);

    // E expansion. DES bit n is r[32-n].
    function automatic logic [47:0] expand_e(input logic [31:0] r);
        return {r[0], r[31:27], r[28:23], r[24:19], r[20:15],
                r[16:11], r[12:7], r[8:3], r[4:0], r[31]};
    endfunction

    // P permutation. Output DES bit k takes s-vector DES bit P[k], that is s[32-P[k]].
    function automatic logic [31:0] perm_p(input logic [31:0] s);
        return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
                s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
                s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
                s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
    endfunction

    logic [47:0] x_p1;
    logic [31:0] l_p1;
    logic [31:0] r_p1;
    logic        last_p1;
    logic        vld_p1;
    logic        vld_p2;
    logic [31:0] s_p1;
    logic [31:0] f_p1;
    logic        adv2;
    logic        in_xfer;

    assign adv2      = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready  = !vld_p1 || adv2;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = vld_p2;

    // Stage 1: expansion and key mix, captured on input transfer
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_p1  <= 1'b0;
            x_p1    <= '0;
            l_p1    <= '0;
            r_p1    <= '0;
            last_p1 <= 1'b0;
        end else if (in_xfer) begin
            vld_p1  <= 1'b1;
            x_p1    <= expand_e(r_in) ^ subkey;
            l_p1    <= l_in;
            r_p1    <= r_in;
            last_p1 <= last_round;
        end else if (adv2) begin
            vld_p1  <= 1'b0;
        end
    end

    // Stage 1 -> 2: substitution and permutation (combinational)
    s_box1 u_s1 (.in_6bit(x_p1[47:42]), .out_4bit(s_p1[31:28]));
    s_box2 u_s2 (.in_6bit(x_p1[41:36]), .out_4bit(s_p1[27:24]));
    s_box3 u_s3 (.in_6bit(x_p1[35:30]), .out_4bit(s_p1[23:20]));
    s_box4 u_s4 (.in_6bit(x_p1[29:24]), .out_4bit(s_p1[19:16]));
    s_box5 u_s5 (.in_6bit(x_p1[23:18]), .out_4bit(s_p1[15:12]));
    s_box6 u_s6 (.in_6bit(x_p1[17:12]), .out_4bit(s_p1[11:8]));
    s_box7 u_s7 (.in_6bit(x_p1[11:6]),  .out_4bit(s_p1[7:4]));
    s_box8 u_s8 (.in_6bit(x_p1[5:0]),   .out_4bit(s_p1[3:0]));

    assign f_p1 = perm_p(s_p1);

    // Stage 2: output register; it only loads on advance, so it stays stable while stalled
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_p2 <= 1'b0;
            l_out  <= '0;
            r_out  <= '0;
        end else if (adv2) begin
            vld_p2 <= 1'b1;
            if (last_p1) begin
                l_out <= l_p1 ^ f_p1;
                r_out <= r_p1;
            end else begin
                l_out <= r_p1;
                r_out <= l_p1 ^ f_p1;
            end
        end else if (out_ready) begin
            vld_p2 <= 1'b0;
        end
    end

endmodule

// S-box tables. The rows are packed left to right in FIPS order, so entry
// (row*16 + col) sits at bits [255-4k -: 4]. That start bit is {~k, 2'b11}.
// The row is formed from DES bits 1 and 6, and the column from bits 2..5.
module s_box1 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
    localparam logic [255:0] TBL = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                                    64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
    logic [5:0] idx;
    assign idx      = {in_6bit[5], in_6bit[0], in_6bit[4:1]};
    assign out_4bit = TBL[{~idx, 2'b11} -: 4];
endmodule

module s_box2 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
    localparam logic [255:0] TBL = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                                    64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
    logic [5:0] idx;
    assign idx      = {in_6bit[5], in_6bit[0], in_6bit[4:1]};
    assign out_4bit = TBL[{~idx, 2'b11} -: 4];
endmodule

module s_box3 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
    localparam logic [255:0] TBL = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                                    64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
    logic [5:0] idx;
    assign idx      = {in_6bit[5], in_6bit[0], in_6bit[4:1]};
    assign out_4bit = TBL[{~idx, 2'b11} -: 4];
endmodule

module s_box4 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
    localparam logic [255:0] TBL = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                                    64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
    logic [5:0] idx;
    assign idx      = {in_6bit[5], in_6bit[0], in_6bit[4:1]};
    assign out_4bit = TBL[{~idx, 2'b11} -: 4];
endmodule

module s_box5 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
    localparam logic [255:0] TBL = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                                    64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
    logic [5:0] idx;
    assign idx      = {in_6bit[5], in_6bit[0], in_6bit[4:1]};
    assign out_4bit = TBL[{~idx, 2'b11} -: 4];
endmodule

module s_box6 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
    localparam logic [255:0] TBL = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                                    64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
    logic [5:0] idx;
    assign idx      = {in_6bit[5], in_6bit[0], in_6bit[4:1]};
    assign out_4bit = TBL[{~idx, 2'b11} -: 4];
endmodule

module s_box7 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
    localparam logic [255:0] TBL = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                                    64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
    logic [5:0] idx;
    assign idx      = {in_6bit[5], in_6bit[0], in_6bit[4:1]};
    assign out_4bit = TBL[{~idx, 2'b11} -: 4];
endmodule

module s_box8 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
    localparam logic [255:0] TBL = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                                    64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
    logic [5:0] idx;
    assign idx      = {in_6bit[5], in_6bit[0], in_6bit[4:1]};
    assign out_4bit = TBL[{~idx, 2'b11} -: 4];
endmodule

// File: doc/des_round_pipe.md
Name: des_round_pipe

Overview:
- Two-stage pipelined DES Feistel round: expansion E, subkey XOR, the eight S-box substitutions (instances of s_box1..s_box8), permutation P, and XOR with the left half.
- Sits between the round controller / key scheduler (upstream) and the next round or final permutation (downstream).
- Valid/ready handshake with full backpressure.
- Sustains one round per clock when not stalled.

Parameters:
- none (DES widths fixed by FIPS 46-3)

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents l_in/r_in/subkey/last_round
- in_ready  output  1  block accepts input this cycle
- l_in  input  32  left half L(i-1); DES bit 1 = [31]
- r_in  input  32  right half R(i-1); DES bit 1 = [31]
- subkey  input  48  round key K(i); DES bit 1 = [47]
- last_round  input  1  1 = round 16, no half swap
- out_valid  output  1  l_out/r_out valid
- out_ready  input  1  downstream accepts output
- l_out  output  32  new left half
- r_out  output  32  new right half

Behaviour:
- Reset (n_rst low, asynchronous): all pipeline valid flags clear.
  - Output values during reset: out_valid=0, l_out=0, r_out=0, in_ready=1.
  - All data registers clear to 0.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready on a rising edge.
  - Output transfer occurs when out_valid && out_ready on a rising edge.
- Stage 1 (capture):
  - Registers x1 = E(r_in) XOR subkey (48 b), l_in, r_in, last_round, and v1.
  - E per FIPS 46-3 table; bit 1 = MSB.
- Stage 2 (output register):
  - Combinational from stage-1 registers:
    - S-box i takes x1[47-6(i-1) : 42-6(i-1)] in in_6bit bit order, so DES bit 1 = in_6bit[5].
    - S-box i output drives s[31-4(i-1) : 28-4(i-1)].
    - f = P(s), per FIPS 46-3 table.
  - last_round=0: l_out <= R, r_out <= L XOR f.
  - last_round=1: l_out <= L XOR f, r_out <= R.
  - out_valid <= v1 on advance.
- Stall logic (no bubbles, no skid buffer):
  - adv2 = v1 && (!out_valid || out_ready)
  - in_ready = !v1 || adv2
- Stage hold/clear:
  - Stage 1 loads on input transfer.
  - Otherwise v1 clears when adv2.
  - Otherwise stage 1 holds.
  - out_valid clears on output transfer without a concurrent adv2.
- Output stability: while out_valid=1 and out_ready=0, l_out/r_out held bit-stable.
- Latency: input transfer at edge N gives out_valid=1 after edge N+1, i.e. 2 cycles.
- Throughput: 1 round/cycle with out_ready held 1.
- Simultaneous events:
  - Full pipe plus output transfer plus new input in the same cycle: all three occur; no data lost or duplicated.
  - in_valid while in_ready=0: ignored; upstream must hold values.
- Reset mid-operation: in-flight data discarded; no out_valid pulse after reset release until a new input transfer.
- Out-of-range S-box rows are impossible; no X may propagate to l_out/r_out when v1=1.
- Inputs sampled only on transfer; changes at other times have no effect.

Test Plan:
- FIPS round-1 vector, no swap:
  - Stimulus: l_in=0xCC00CCFF, r_in=0xF0AAF0AA, subkey=0x1B02EFFC7072, last_round=0, out_ready=1.
  - Expect internal x1=0x6117BA866527, S-output 0x5C82B597, f=0x234AA9BB.
  - Expect l_out=0xF0AAF0AA, r_out=0xEF4A6544, out_valid exactly 2 cycles after accept.
- Same vector, last_round=1 -> l_out=0xEF4A6544, r_out=0xF0AAF0AA.
- Back-to-back throughput:
  - Stimulus: 16 consecutive inputs, out_ready=1.
  - Expect in_ready constantly 1, 16 consecutive out_valid cycles, outputs in order and matching a reference model.
- Backpressure:
  - Stimulus: out_ready=0 with 3 inputs offered.
  - Expect: 2 accepted, then in_ready=0; l_out/r_out stable while stalled.
  - Stimulus: raise out_ready.
  - Expect: both results delivered in order and the third input accepted in the same cycle as the first output transfer.
- Reset mid-operation:
  - Stimulus: assert n_rst asynchronously with both stages full.
  - Expect out_valid=0, l_out=r_out=0 immediately, in_ready=1, and no spurious output after release.
- Random stimulus: 10k random L/R/K/last_round with random in_valid/out_ready, checked against a software DES round model -> zero mismatches, no drops or duplicates.
